lockstep_trace_checker: RTL and testbench

- Synthesisable multi-channel lockstep checker that compares event streams from a DUT CPU against a golden CPU.
- Per-channel FIFOs decouple the two streams, so the two cores may differ in timing.
- Latches the first divergence and detects benchmark completion.
- Instantiated beside cpu_test_top / cpu_test_top_golden in simulation and FPGA self-check builds.

---
 rtl/lockstep_pkg.sv | 16 +
 rtl/lockstep_fifo.sv | 55 +++++
 rtl/lockstep_trace_checker.sv | 198 +++++++++++++++++++
 tb/tb_lockstep_trace_checker.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep trace checker.
// Fail codes and checker state encoding.
package lockstep_pkg;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_OVERFLOW = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_e;

endpackage

// File: rtl/lockstep_fifo.sv
// First-word-fall-through synchronous FIFO.
// A push into a full FIFO is accepted only with a same-cycle pop.
module lockstep_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr, rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign dout  = mem_q[rptr_q];
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/lockstep_trace_checker.sv
// Multi-channel DUT-vs-golden lockstep event checker.
// Define LOCKSTEP_MASK_EN to add the per-event cmp_mask input.
module lockstep_trace_checker
  import lockstep_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          W         = 64,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADDR = 32'h0000000C,
  parameter logic [31:0] PASS_DATA = 32'h00000000,
  parameter int unsigned TIMEOUT   = 1000000,
  localparam int         CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic [N_CH-1:0]   dut_valid,
  input  logic [N_CH*W-1:0] dut_data,
  input  logic [N_CH-1:0]   gold_valid,
  input  logic [N_CH*W-1:0] gold_data,
`ifdef LOCKSTEP_MASK_EN
  input  logic [N_CH*W-1:0] cmp_mask,
`endif
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [CW-1:0]     fail_ch,
  output logic [W-1:0]      fail_dut,
  output logic [W-1:0]      fail_gold,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       fail_cycle
);

`ifdef LOCKSTEP_MASK_EN
  localparam int FW = 2 * W;
`else
  localparam int FW = W;
`endif
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [1:0]      code_q, code_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [W-1:0]    fdut_q, fdut_d;
  logic [W-1:0]    fgold_q, fgold_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     fcyc_q, fcyc_d;
  logic [31:0]     tmo_q, tmo_d;

  logic            run;
  logic [N_CH-1:0] d_push, g_push, pop;
  logic [N_CH-1:0] d_empty, d_full;
  logic [N_CH-1:0] g_empty, g_full;
  logic [N_CH-1:0] ovf, mis;
  logic [FW-1:0]   d_dout [N_CH];
  logic [W-1:0]    g_dout [N_CH];
  logic [W-1:0]    d_cmp  [N_CH];
  logic [W-1:0]    g_cmp  [N_CH];

  assign run    = (state_q == S_RUN);
  assign d_push = {N_CH{run}} & dut_valid;
  assign g_push = {N_CH{run}} & gold_valid;
  assign pop    = {N_CH{run}} & ~d_empty & ~g_empty;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [FW-1:0] d_din;
`ifdef LOCKSTEP_MASK_EN
    assign d_din    = {cmp_mask[c*W +: W], dut_data[c*W +: W]};
    assign d_cmp[c] = d_dout[c][W-1:0] & d_dout[c][FW-1:W];
    assign g_cmp[c] = g_dout[c] & d_dout[c][FW-1:W];
`else
    assign d_din    = dut_data[c*W +: W];
    assign d_cmp[c] = d_dout[c];
    assign g_cmp[c] = g_dout[c];
`endif
    // a full FIFO only overflows if nothing leaves it this cycle
    assign ovf[c] = (d_push[c] & d_full[c] & ~pop[c])
                  | (g_push[c] & g_full[c] & ~pop[c]);
    assign mis[c] = pop[c] & (d_cmp[c] != g_cmp[c]);

    lockstep_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_dut_fifo (
      .clk  (sys_clk),
      .rst_n(sys_reset_n),
      .push (d_push[c]),
      .pop  (pop[c]),
      .din  (d_din),
      .dout (d_dout[c]),
      .empty(d_empty[c]),
      .full (d_full[c])
    );

    lockstep_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_gold_fifo (
      .clk  (sys_clk),
      .rst_n(sys_reset_n),
      .push (g_push[c]),
      .pop  (pop[c]),
      .din  (gold_data[c*W +: W]),
      .dout (g_dout[c]),
      .empty(g_empty[c]),
      .full (g_full[c])
    );
  end

  logic          ovf_hit, mis_hit, tmo_hit, pass_hit;
  logic [CW-1:0] ovf_ch, mis_ch;

  always_comb begin
    ovf_hit = 1'b0;
    mis_hit = 1'b0;
    ovf_ch  = '0;
    mis_ch  = '0;
    // descending scan leaves the lowest flagged channel
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (ovf[c]) begin
        ovf_hit = 1'b1;
        ovf_ch  = CW'(c);
      end
      if (mis[c]) begin
        mis_hit = 1'b1;
        mis_ch  = CW'(c);
      end
    end
  end

  assign tmo_hit  = (TIMEOUT != 0) && !(|dut_valid)
                 && (tmo_q == TMO_LAST);
  assign pass_hit = mem_wen && (mem_addr == PASS_ADDR)
                 && (mem_wdata == PASS_DATA);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ch_d    = ch_q;
    fdut_d  = fdut_q;
    fgold_d = fgold_q;
    fcyc_d  = fcyc_q;
    tmo_d   = tmo_q;
    cyc_d   = (cyc_q == 32'hFFFFFFFF) ? cyc_q : cyc_q + 1;
    if (run) begin
      tmo_d = (|dut_valid) ? '0 : tmo_q + 1;
      if (ovf_hit) begin
        state_d = S_FAIL;
        code_d  = FC_OVERFLOW;
        ch_d    = ovf_ch;
        fcyc_d  = cyc_q;
      end else if (mis_hit) begin
        state_d = S_FAIL;
        code_d  = FC_MISMATCH;
        ch_d    = mis_ch;
        fdut_d  = d_cmp[mis_ch];
        fgold_d = g_cmp[mis_ch];
        fcyc_d  = cyc_q;
      end else if (tmo_hit) begin
        state_d = S_FAIL;
        code_d  = FC_TIMEOUT;
        fcyc_d  = cyc_q;
      end else if (pass_hit) begin
        state_d = S_PASS;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q <= S_RUN;
      code_q  <= FC_NONE;
      ch_q    <= '0;
      fdut_q  <= '0;
      fgold_q <= '0;
      cyc_q   <= '0;
      fcyc_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ch_q    <= ch_d;
      fdut_q  <= fdut_d;
      fgold_q <= fgold_d;
      cyc_q   <= cyc_d;
      fcyc_q  <= fcyc_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pass       = (state_q == S_PASS);
  assign fail       = (state_q == S_FAIL);
  assign done       = pass | fail;
  assign fail_code  = code_q;
  assign fail_ch    = ch_q;
  assign fail_dut   = fdut_q;
  assign fail_gold  = fgold_q;
  assign cycle_cnt  = cyc_q;
  assign fail_cycle = fcyc_q;

endmodule

// File: tb/tb_lockstep_trace_checker.sv
// Scoreboard bench for lockstep_trace_checker.
// Build with LOCKSTEP_MASK_EN to also exercise the compare mask.
module tb_lockstep_trace_checker;

  localparam int N_CH = 4;
  localparam int W    = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   dut_valid = '0;
  logic [N_CH*W-1:0] dut_data = '0;
  logic [N_CH-1:0]   gold_valid = '0;
  logic [N_CH*W-1:0] gold_data = '0;
  logic [N_CH*W-1:0] cmp_mask = '0;
  logic              mem_wen = 1'b0;
  logic [31:0]       mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic              done, pass, fail;
  logic [1:0]        fail_code;
  logic [1:0]        fail_ch;
  logic [W-1:0]      fail_dut, fail_gold;
  logic [31:0]       cycle_cnt, fail_cycle;

  lockstep_trace_checker #(
    .N_CH(N_CH), .W(W), .DEPTH(8),
    .PASS_ADDR(32'h0000000C), .PASS_DATA(32'h0),
    .TIMEOUT(100)
  ) dut (
    .sys_clk    (clk),
    .sys_reset_n(rst_n),
    .dut_valid  (dut_valid),
    .dut_data   (dut_data),
    .gold_valid (gold_valid),
    .gold_data  (gold_data),
`ifdef LOCKSTEP_MASK_EN
    .cmp_mask   (cmp_mask),
`endif
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code),
    .fail_ch    (fail_ch),
    .fail_dut   (fail_dut),
    .fail_gold  (fail_gold),
    .cycle_cnt  (cycle_cnt),
    .fail_cycle (fail_cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [1:0]  ch;
    logic [63:0] fdut;
    logic [63:0] fgold;
    logic [31:0] fcyc;
    logic [31:0] dcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   seen = 1'b0;
  int   cyc = 0;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: checks the terminal outcome when done first rises
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen = 1'b0;
    else if (done && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {fail, fail_code}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pass", pass, e.pass);
        chk("fail", fail, e.fail);
        chk("fail_code", fail_code, e.code);
        chk("fail_ch", fail_ch, e.ch);
        chk("fail_dut", fail_dut, e.fdut);
        chk("fail_gold", fail_gold, e.fgold);
        chk("fail_cycle", fail_cycle, e.fcyc);
        chk("done_cycle_cnt", cycle_cnt, e.dcnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ev(input int i, input int c);
    return {32'hA500_0000 + 32'(c), 32'(i * 7 + 1)};
  endfunction

  task automatic idle_inputs();
    dut_valid  = '0;
    gold_valid = '0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_flags", {done, pass, fail, fail_code, fail_ch}, 0);
    chk("rst_payload", fail_dut | fail_gold, 0);
    chk("rst_counts", {cycle_cnt, fail_cycle}, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_sb(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("scoreboard_drain", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic push_exp(input logic p, input logic [1:0] code,
                          input logic [1:0] ch, input logic [63:0] fd,
                          input logic [63:0] fg, input int fc,
                          input int dc);
    exp_t e;
    e.pass  = p;
    e.fail  = !p;
    e.code  = code;
    e.ch    = ch;
    e.fdut  = fd;
    e.fgold = fg;
    e.fcyc  = 32'(fc);
    e.dcnt  = 32'(dc);
    exp_q.push_back(e);
  endtask

  task automatic pass_write();
    mem_wen   = 1'b1;
    mem_addr  = 32'h0000000C;
    mem_wdata = 32'h0;
  endtask

  initial begin
    int k;

    // identical streams, near-miss writes, then the pass write
    do_reset();
    for (int i = 0; i < 100; i++) begin
      dut_valid  = '1;
      gold_valid = '1;
      for (int c = 0; c < N_CH; c++) begin
        dut_data[c*W +: W]  = ev(i, c);
        gold_data[c*W +: W] = ev(i, c);
      end
      tick();
    end
    idle_inputs();
    mem_wen = 1'b1; mem_addr = 32'hC; mem_wdata = 32'h1;
    tick();
    mem_addr = 32'h8; mem_wdata = 32'h0;
    tick();
    idle_inputs();
    tick();
    chk("no_done_near_miss", {done, fail}, 0);
    k = cyc;
    push_exp(1'b1, 2'd0, 2'd0, 0, 0, 0, k + 1);
    pass_write();
    tick();
    idle_inputs();
    wait_sb(10);
    // terminal PASS ignores a mismatching stream
    for (int i = 0; i < 3; i++) begin
      dut_valid  = 4'b0001;
      gold_valid = 4'b0001;
      dut_data[0 +: W]  = 64'h1;
      gold_data[0 +: W] = 64'h2;
      tick();
    end
    idle_inputs();
    tick();
    chk("pass_frozen", {pass, fail, fail_code}, {1'b1, 1'b0, 2'd0});
    chk("cycle_cnt_runs", cycle_cnt, 32'(cyc));

    // golden lagging by 5 cycles, then ch2 overflow
    do_reset();
    for (int t = 0; t < 55; t++) begin
      dut_valid  = (t < 50) ? 4'hF : 4'h0;
      gold_valid = (t >= 5) ? 4'hF : 4'h0;
      for (int c = 0; c < N_CH; c++) begin
        dut_data[c*W +: W]  = ev(t, c);
        gold_data[c*W +: W] = ev(t - 5, c);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
    chk("no_fail_lag", {done, fail}, 0);
    for (int j = 0; j < 9; j++) begin
      dut_valid = 4'b0100;
      dut_data[2*W +: W] = 64'(j);
      if (j == 8) begin
        k = cyc;
        push_exp(1'b0, 2'd2, 2'd2, 0, 0, k, k + 1);
      end
      tick();
    end
    idle_inputs();
    wait_sb(10);

    // ch1 event 7 diverges
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dut_valid  = '1;
      gold_valid = '1;
      for (int c = 0; c < N_CH; c++) begin
        dut_data[c*W +: W]  = ev(i, c);
        gold_data[c*W +: W] = ev(i, c);
      end
      if (i == 7) begin
        dut_data[1*W +: W]  = 64'h1234;
        gold_data[1*W +: W] = 64'h1235;
        k = cyc;
        push_exp(1'b0, 2'd1, 2'd1, 64'h1234, 64'h1235, k + 1, k + 2);
      end
      tick();
    end
    idle_inputs();
    wait_sb(10);

    // ch0 and ch3 diverge while the pass write is seen
    do_reset();
    dut_valid  = '1;
    gold_valid = '1;
    for (int c = 0; c < N_CH; c++) begin
      dut_data[c*W +: W]  = ev(3, c);
      gold_data[c*W +: W] = ev(3, c);
    end
    dut_data[0*W +: W]  = 64'hAAAA;
    gold_data[0*W +: W] = 64'hBBBB;
    dut_data[3*W +: W]  = 64'hCCCC;
    gold_data[3*W +: W] = 64'hDDDD;
    k = cyc;
    push_exp(1'b0, 2'd1, 2'd0, 64'hAAAA, 64'hBBBB, k + 1, k + 2);
    tick();
    idle_inputs();
    pass_write();
    tick();
    idle_inputs();
    wait_sb(10);

    // idle after reset times out, then reset mid-FAIL resumes checking
    do_reset();
    push_exp(1'b0, 2'd3, 2'd0, 0, 0, 99, 100);
    wait_sb(150);
    do_reset();
    dut_valid  = 4'b1000;
    gold_valid = 4'b1000;
    dut_data[3*W +: W]  = 64'h55;
    gold_data[3*W +: W] = 64'h66;
    k = cyc;
    push_exp(1'b0, 2'd1, 2'd3, 64'h55, 64'h66, k + 1, k + 2);
    tick();
    idle_inputs();
    wait_sb(10);

`ifdef LOCKSTEP_MASK_EN
    // upper-half differences are masked away
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dut_valid  = '1;
      gold_valid = '1;
      for (int c = 0; c < N_CH; c++) begin
        cmp_mask[c*W +: W]  = 64'h00000000FFFFFFFF;
        dut_data[c*W +: W]  = {32'hDEAD0000 + 32'(i), 32'(i + c)};
        gold_data[c*W +: W] = {32'hBEEF0000, 32'(i + c)};
      end
      tick();
    end
    idle_inputs();
    tick();
    chk("mask_no_fail", {done, fail}, 0);
    k = cyc;
    push_exp(1'b1, 2'd0, 2'd0, 0, 0, 0, k + 1);
    pass_write();
    tick();
    idle_inputs();
    wait_sb(10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
